xbar_port_sched: RTL and testbench

XBAR_PORT_SCHED -- requirements
Module: xbar_port_sched

---
 rtl/xbar_port_sched.sv | 172 +++++++++++++++++
 tb/tb_xbar_port_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_port_sched.sv
// xbar_port_sched
// Two-requester scheduler in front of one shared slave port. A small FSM
// grants one requester at a time. When both are eligible, the grant
// alternates. Read grants that the slave accepts are recorded in an
// in-order ID FIFO, so each read response can be routed back to the
// requester that issued it.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant held; arbitrate among eligible requesters
// BUSY  | requester g owns the shared port until m_ack or abort
//
// Ports
//   aclk, areset         clock, synchronous active-high reset
//   sN_req/addr/cmd/wdata requester N request (cmd 0 = read, 1 = write)
//   sN_ack               one-cycle accept pulse to requester N
//   sN_rdata/sN_resp     read data and response strobe to requester N
//   m_req/addr/cmd/wdata shared port request, muxed from the granted requester
//   m_ack                shared port accepted the request
//   m_rdata/m_resp       read data and response strobe from the shared port
//   resp_err             sticky: a response arrived with no read outstanding
module xbar_port_sched #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s0_req,
    input  logic [AWIDTH-1:0] s0_addr,
    input  logic              s0_cmd,
    input  logic [DWIDTH-1:0] s0_wdata,
    output logic              s0_ack,
    output logic [DWIDTH-1:0] s0_rdata,
    output logic              s0_resp,
    input  logic              s1_req,
    input  logic [AWIDTH-1:0] s1_addr,
    input  logic              s1_cmd,
    input  logic [DWIDTH-1:0] s1_wdata,
    output logic              s1_ack,
    output logic [DWIDTH-1:0] s1_rdata,
    output logic              s1_resp,
    output logic              m_req,
    output logic [AWIDTH-1:0] m_addr,
    output logic              m_cmd,
    output logic [DWIDTH-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DWIDTH-1:0] m_rdata,
    input  logic              m_resp,
    output logic              resp_err
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(OUTSTANDING);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic                   g;
    logic                   lg;
    logic [CW-1:0]          count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [OUTSTANDING-1:0] id_mem;

    logic busy;
    logic fifo_full;
    logic fifo_empty;
    logic elig0;
    logic elig1;
    logic gnt_req;
    logic gnt_cmd;
    logic accept;
    logic push;
    logic pop;
    logic head;

    assign busy       = (state == BUSY);
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // A full ID FIFO blocks only reads; writes never produce a response.
    assign elig0 = s0_req && !(!s0_cmd && fifo_full);
    assign elig1 = s1_req && !(!s1_cmd && fifo_full);

    assign gnt_req = g ? s1_req : s0_req;
    assign gnt_cmd = g ? s1_cmd : s0_cmd;

    always_comb begin
        m_req   = 1'b0;
        m_addr  = '0;
        m_cmd   = 1'b0;
        m_wdata = '0;
        if (busy) begin
            m_req   = gnt_req;
            m_addr  = g ? s1_addr  : s0_addr;
            m_cmd   = gnt_cmd;
            m_wdata = g ? s1_wdata : s0_wdata;
        end
    end

    assign accept = busy && m_ack;
    assign s0_ack = accept && !g;
    assign s1_ack = accept && g;

    assign push = accept && !gnt_cmd;
    assign pop  = m_resp && !fifo_empty;
    assign head = id_mem[rd_ptr];

    assign s0_resp  = pop && !head;
    assign s1_resp  = pop && head;
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            g        <= 1'b0;
            lg       <= 1'b1;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 && elig1) begin
                        g     <= !lg;
                        state <= BUSY;
                    end else if (elig0) begin
                        g     <= 1'b0;
                        state <= BUSY;
                    end else if (elig1) begin
                        g     <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        lg    <= g;
                        state <= IDLE;
                    end else if (!gnt_req) begin
                        // abort: drop the grant without touching lg
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (m_resp && fifo_empty) resp_err <= 1'b1;
        end
    end

    // ID storage needs no reset; only slots between rd_ptr and wr_ptr are read.
    always_ff @(posedge aclk) begin
        if (push) id_mem[wr_ptr] <= g;
    end

endmodule

// File: tb/tb_xbar_port_sched.sv
module tb_xbar_port_sched;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s0_req, s0_cmd, s1_req, s1_cmd;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [DW-1:0] s0_wdata, s1_wdata;
    logic          s0_ack, s1_ack, s0_resp, s1_resp;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          m_req, m_cmd, m_ack, m_resp, resp_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 aclk = ~aclk;

    xbar_port_sched #(.AWIDTH(AW), .DWIDTH(DW), .OUTSTANDING(4)) dut (
        .aclk(aclk), .areset(areset),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_cmd(s0_cmd), .s0_wdata(s0_wdata),
        .s0_ack(s0_ack), .s0_rdata(s0_rdata), .s0_resp(s0_resp),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_cmd(s1_cmd), .s1_wdata(s1_wdata),
        .s1_ack(s1_ack), .s1_rdata(s1_rdata), .s1_resp(s1_resp),
        .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_resp(m_resp), .resp_err(resp_err)
    );

    task automatic apply_reset();
        @(negedge aclk);
        areset = 1'b1;
        s0_req = 0; s1_req = 0; s0_cmd = 0; s1_cmd = 0;
        s0_addr = '0; s1_addr = '0; s0_wdata = '0; s1_wdata = '0;
        m_ack = 0; m_resp = 0; m_rdata = '0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        exp_q.delete();
    endtask

    // Wait for m_req, check the forwarded fields, ack it and check the
    // requester ack. Reads are pushed to the scoreboard with the id the
    // arbitration rules predict. Returns just after the accepting edge.
    task automatic do_xact(input int exp_id, input logic exp_cmd, input logic [AW-1:0] exp_addr);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (m_req === 1'b1) begin
                seen = 1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL xact_wait: m_req never asserted, required 1 for id %0d", exp_id);
            return;
        end
        vectors++;
        if (m_addr !== exp_addr || m_cmd !== exp_cmd) begin
            miscompares++;
            $display("FAIL xact_fields: addr=%h cmd=%b, required addr=%h cmd=%b",
                     m_addr, m_cmd, exp_addr, exp_cmd);
        end
        m_ack = 1'b1;
        #1;
        vectors++;
        if (s0_ack !== (exp_id == 0) || s1_ack !== (exp_id == 1)) begin
            miscompares++;
            $display("FAIL xact_ack: s0_ack=%b s1_ack=%b, required grant id %0d",
                     s0_ack, s1_ack, exp_id);
        end
        if (!exp_cmd) exp_q.push_back(exp_id);
        @(posedge aclk);
        #1;
        m_ack = 1'b0;
        vectors++;
        if (m_req !== 1'b0) begin
            miscompares++;
            $display("FAIL xact_spacing: m_req=%b in cycle after ack, required 0", m_req);
        end
    endtask

    // Drive one m_resp and compare against the scoreboard head.
    task automatic do_resp(input logic [DW-1:0] data);
        int  id;
        bit  want;
        @(negedge aclk);
        m_resp  = 1'b1;
        m_rdata = data;
        #1;
        want = (exp_q.size() != 0);
        id = want ? exp_q.pop_front() : -1;
        vectors++;
        if (s0_resp !== (want && id == 0) || s1_resp !== (want && id == 1)) begin
            miscompares++;
            $display("FAIL resp_route: s0_resp=%b s1_resp=%b, required id %0d (-1 = none)",
                     s0_resp, s1_resp, id);
        end
        if (want) begin
            vectors++;
            if (s0_rdata !== data || s1_rdata !== data) begin
                miscompares++;
                $display("FAIL resp_data: s0_rdata=%h s1_rdata=%h, required %h",
                         s0_rdata, s1_rdata, data);
            end
        end
        @(posedge aclk);
        #1;
        m_resp = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if (m_req !== 0 || s0_ack !== 0 || s1_ack !== 0 || s0_resp !== 0 ||
            s1_resp !== 0 || resp_err !== 0 || m_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_state: m_req=%b acks=%b%b resps=%b%b err=%b addr=%h, required all 0",
                     m_req, s0_ack, s1_ack, s0_resp, s1_resp, resp_err, m_addr);
        end
    endtask

    task automatic test_alternation();
        apply_reset();
        s0_req = 1; s0_cmd = 0; s0_addr = 32'h100;
        s1_req = 1; s1_cmd = 0; s1_addr = 32'h200;
        do_xact(0, 1'b0, 32'h100);
        do_xact(1, 1'b0, 32'h200);
        do_xact(0, 1'b0, 32'h100);
        do_xact(1, 1'b0, 32'h200);
        s0_req = 0; s1_req = 0;
        do_resp(32'hA0A0_0001);
        do_resp(32'hA0A0_0002);
        do_resp(32'hA0A0_0003);
        do_resp(32'hA0A0_0004);
    endtask

    task automatic test_s1_read();
        apply_reset();
        s1_req = 1; s1_cmd = 0; s1_addr = 32'h10;
        do_xact(1, 1'b0, 32'h10);
        s1_req = 0;
        repeat (2) @(negedge aclk);
        do_resp(32'hDEADBEEF);
    endtask

    task automatic test_full();
        bit leak = 0;
        apply_reset();
        s0_req = 1; s0_cmd = 0;
        for (int i = 0; i < 4; i++) begin
            s0_addr = 32'h400 + 32'(i);
            do_xact(0, 1'b0, 32'h400 + 32'(i));
        end
        s0_addr = 32'h404;
        s1_req = 1; s1_cmd = 1; s1_addr = 32'h500; s1_wdata = 32'h1234_5678;
        do_xact(1, 1'b1, 32'h500);
        vectors++;
        if (m_wdata !== '0) begin
            miscompares++;
            $display("FAIL full_wdata_idle: m_wdata=%h, required 0 while idle", m_wdata);
        end
        s1_req = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (m_req !== 1'b0) leak = 1;
        end
        vectors++;
        if (leak) begin
            miscompares++;
            $display("FAIL full_block: m_req=1 with FIFO full, required 0");
        end
        do_resp(32'hB000_0000);
        do_xact(0, 1'b0, 32'h404);
        s0_req = 0;
        for (int i = 1; i <= 4; i++) do_resp(32'hB000_0000 + 32'(i));
        vectors++;
        if (resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_err: resp_err=%b, required 0", resp_err);
        end
    endtask

    task automatic test_spurious_resp();
        apply_reset();
        do_resp(32'hCAFE_F00D);
        @(negedge aclk);
        vectors++;
        if (resp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL spurious_err_set: resp_err=%b, required 1", resp_err);
        end
        repeat (5) @(negedge aclk);
        vectors++;
        if (resp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL spurious_err_sticky: resp_err=%b, required 1", resp_err);
        end
    endtask

    task automatic test_reset_midflight();
        bit seen = 0;
        apply_reset();
        #1;
        vectors++;
        if (resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clears_err: resp_err=%b, required 0", resp_err);
        end
        s0_req = 1; s0_cmd = 0; s0_addr = 32'h600;
        do_xact(0, 1'b0, 32'h600);
        do_xact(0, 1'b0, 32'h600);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (m_req === 1'b1) begin
                seen = 1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midflight_busy: m_req never asserted, required 1");
        end
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        s0_req = 0;
        exp_q.delete();
        vectors++;
        if (m_req !== 1'b0 || s0_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_reset: m_req=%b s0_ack=%b, required 0", m_req, s0_ack);
        end
        do_resp(32'h1111_2222);
        @(negedge aclk);
        vectors++;
        if (resp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight_err: resp_err=%b, required 1", resp_err);
        end
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_s1_read();
        test_full();
        test_spurious_resp();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
